// File: rtl/minterm_dec_unit.sv
// Programmable sum-of-minterms unit: registered one-hot decode and F lookup
// behind a valid/ready stage, plus a sweep that counts the mask's on-set.
//
//  state | meaning
//  IDLE  | evaluating input vectors, accepting sweep requests
//  SWEEP | walking idx 0..NM-1, accumulating on-set bits
//  DONE  | publishing sweep_count and pulsing sweep_done
module minterm_dec_unit #(
  parameter int N_IN   = 4,
  parameter int LOAD_W = 8,
  localparam int NM    = 1 << N_IN,
  localparam int NCH   = NM / LOAD_W,
  localparam int CA    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic              cfg_wr,
  input  logic [CA-1:0]     cfg_addr,
  input  logic [LOAD_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_f,
  output logic [NM-1:0]     out_onehot,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [N_IN:0]     sweep_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(NM - 1);

  logic [NM-1:0] mask;
  logic [1:0]    state;
  logic [N_IN:0] idx;
  logic [N_IN:0] acc;
  logic          drain_ok;
  logic          sweep_take;
  logic          accept;

  // A sweep may start only when the output register is empty or emptying now.
  assign drain_ok   = !out_valid || out_ready;
  assign sweep_take = (state == IDLE) && sweep_start && drain_ok;
  assign in_ready   = (state == IDLE) && drain_ok && !sweep_take;
  assign accept     = in_valid && in_ready;
  assign sweep_busy = (state == SWEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (cfg_wr && !sweep_busy) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(cfg_addr) == c) mask[c*LOAD_W +: LOAD_W] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_f      <= 1'b0;
      out_onehot <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_f      <= mask[in_vec] & ~en_n;
      out_onehot <= en_n ? '0 : (NM'(1) << in_vec);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      sweep_done  <= 1'b0;
      sweep_count <= '0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_take) begin
            state <= SWEEP;
            idx   <= '0;
            acc   <= '0;
          end
        end
        SWEEP: begin
          acc <= acc + {{N_IN{1'b0}}, mask[idx[N_IN-1:0]] & ~en_n};
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= DONE;
        end
        DONE: begin
          sweep_count <= acc;
          sweep_done  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_dec_unit.sv
// Directed bench for minterm_dec_unit: decode/F table, sweeps, backpressure,
// enable gating, config corner cases and asynchronous reset mid-sweep.
module tb_minterm_dec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_n;
  logic        cfg_wr;
  logic [0:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vec;
  logic        out_valid;
  logic        out_ready;
  logic        out_f;
  logic [15:0] out_onehot;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [4:0]  sweep_count;

  // second instance with a single config chunk, so chunk 1 is out of range
  logic        cfg_wr2;
  logic [0:0]  cfg_addr2;
  logic [7:0]  cfg_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic [2:0]  in_vec2;
  logic        out_valid2;
  logic        out_f2;
  logic [7:0]  out_onehot2;
  logic        sweep_busy2;
  logic        sweep_done2;
  logic [3:0]  sweep_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  minterm_dec_unit #(.N_IN(4), .LOAD_W(8)) dut (
    .clk(clk), .rst(rst), .en_n(en_n),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_onehot(out_onehot), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_count(sweep_count)
  );

  minterm_dec_unit #(.N_IN(3), .LOAD_W(8)) dut2 (
    .clk(clk), .rst(rst), .en_n(en_n),
    .cfg_wr(cfg_wr2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_vec(in_vec2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_f(out_f2),
    .out_onehot(out_onehot2), .sweep_start(1'b0),
    .sweep_busy(sweep_busy2), .sweep_done(sweep_done2), .sweep_count(sweep_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [0:0] addr, input logic [7:0] data);
    cfg_wr = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_wr = 1'b0;
  endtask

  function automatic bit in_onset(input int v);
    return (v == 4) || (v == 6) || (v == 7) || (v == 8) || (v == 10) || (v == 11);
  endfunction

  task automatic do_sweep(input string tag, input logic [4:0] exp, input bit inject);
    int cnt;
    bit seen;
    in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b1;
    #1;
    chk({tag, "_inrdy"}, in_ready, 0);
    tick();
    sweep_start = 1'b0;
    cnt = 0;
    while (sweep_busy && cnt < 40) begin
      if (inject && cnt == 3) begin
        cfg_wr = 1'b1; cfg_addr = 1'b1; cfg_data = 8'h00;
      end else begin
        cfg_wr = 1'b0;
      end
      cnt++;
      tick();
    end
    cfg_wr = 1'b0;
    chk({tag, "_busy_cycles"}, cnt, 16);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      if (sweep_done) seen = 1'b1;
      else tick();
    end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_count"}, sweep_count, exp);
    tick();
    chk({tag, "_done_pulse"}, sweep_done, 0);
    chk({tag, "_count_held"}, sweep_count, exp);
  endtask

  initial begin
    rst = 1'b1; en_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; sweep_start = 1'b0;
    cfg_wr2 = 1'b0; cfg_addr2 = '0; cfg_data2 = '0; in_valid2 = 1'b0; in_vec2 = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_onehot", out_onehot, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_count", sweep_count, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // write and eval in the same cycle sees the old (cleared) mask
    in_valid = 1'b1; in_vec = 4'd4;
    cfg_wr = 1'b1; cfg_addr = 1'b0; cfg_data = 8'hD0;
    tick();
    cfg_wr = 1'b0;
    chk("wr_same_cycle_old", out_f, 0);
    tick();
    chk("wr_next_cycle_new", out_f, 1);
    in_valid = 1'b0;
    cfg(1'b1, 8'h0D);

    // full decode table, one result per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    for (int v = 0; v < 16; v++) begin
      in_vec = 4'(v);
      #1;
      chk($sformatf("thru_inrdy_%0d", v), in_ready, 1);
      tick();
      chk($sformatf("valid_%0d", v), out_valid, 1);
      chk($sformatf("f_%0d", v), out_f, in_onset(v));
      chk($sformatf("onehot_%0d", v), out_onehot, 32'h1 << v);
    end
    in_valid = 1'b0;

    do_sweep("sw_mask6", 5'd6, 1'b0);
    do_sweep("sw_wr_busy", 5'd6, 1'b1);
    in_valid = 1'b1; in_vec = 4'd8;
    tick();
    in_valid = 1'b0;
    chk("after_busy_wr_f8", out_f, 1);

    // backpressure
    in_valid = 1'b1; in_vec = 4'd6; out_ready = 1'b1;
    tick();
    chk("bp_f6", out_f, 1);
    out_ready = 1'b0; in_vec = 4'd3;
    #1;
    chk("bp_inrdy0", in_ready, 0);
    tick();
    chk("bp_hold1_valid", out_valid, 1);
    chk("bp_hold1_f", out_f, 1);
    chk("bp_hold1_onehot", out_onehot, 32'h0040);
    chk("bp_hold1_inrdy", in_ready, 0);
    tick();
    chk("bp_hold2_f", out_f, 1);
    chk("bp_hold2_onehot", out_onehot, 32'h0040);
    out_ready = 1'b1;
    #1;
    chk("bp_release_inrdy", in_ready, 1);
    tick();
    chk("bp_next_f3", out_f, 0);
    chk("bp_next_onehot", out_onehot, 32'h0008);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // enable gating
    en_n = 1'b1; in_valid = 1'b1; in_vec = 4'd4;
    tick();
    in_valid = 1'b0;
    chk("en_valid", out_valid, 1);
    chk("en_f", out_f, 0);
    chk("en_onehot", out_onehot, 0);
    do_sweep("sw_en_off", 5'd0, 1'b0);
    en_n = 1'b0;

    cfg(1'b0, 8'hFF); cfg(1'b1, 8'hFF);
    do_sweep("sw_all_ones", 5'd16, 1'b0);
    cfg(1'b0, 8'h00); cfg(1'b1, 8'h00);
    do_sweep("sw_zero", 5'd0, 1'b0);

    // single-chunk instance: chunk index 1 is out of range
    cfg_wr2 = 1'b1; cfg_addr2 = 1'b0; cfg_data2 = 8'h81;
    tick();
    cfg_addr2 = 1'b1; cfg_data2 = 8'hFF;
    tick();
    cfg_wr2 = 1'b0; in_valid2 = 1'b1;
    in_vec2 = 3'd1; tick(); chk("oor_f1", out_f2, 0);
    in_vec2 = 3'd7; tick(); chk("oor_f7", out_f2, 1);
    in_vec2 = 3'd0; tick(); chk("oor_f0", out_f2, 1);
    chk("oor_onehot0", out_onehot2, 32'h01);
    in_valid2 = 1'b0;

    // async reset part-way through a sweep
    cfg(1'b0, 8'hD0); cfg(1'b1, 8'h0D);
    do_sweep("sw_pre_rst", 5'd6, 1'b0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_busy", sweep_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", sweep_busy, 0);
    chk("arst_count", sweep_count, 0);
    chk("arst_done", sweep_done, 0);
    chk("arst_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_vec = 4'd4;
    tick();
    in_valid = 1'b0;
    chk("arst_mask_cleared", out_f, 0);
    chk("arst_onehot_after", out_onehot, 32'h0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
